// File: rtl/mc_pkg.sv
// Shared constants, state encoding and select encodings for the multi-cycle MIPS controller.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_J   = 2'b10;
  localparam logic [1:0] PC_SEL_RS  = 2'b11;

  localparam logic [1:0] WSEL_RT    = 2'b00;
  localparam logic [1:0] WSEL_RD    = 2'b01;
  localparam logic [1:0] WSEL_RA    = 2'b10;

  localparam logic [1:0] DSEL_ALU   = 2'b00;
  localparam logic [1:0] DSEL_DM    = 2'b01;
  localparam logic [1:0] DSEL_PC    = 2'b10;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_OR     = 3'b010;
  localparam logic [2:0] ALU_LUI    = 3'b011;

  typedef struct packed {
    logic addu;
    logic subu;
    logic nop;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
  } instr_cls_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, enables and selects out.
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ir_we;
  logic       grf_we;
  logic [1:0] grf_wsel;
  logic [1:0] grf_dsel;
  logic [2:0] alu_op;
  logic       alu_bsel;
  logic       ext_op;
  logic       dm_we;
  logic       dm_re;
  logic       halted;
  logic [2:0] state;

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_sel, ir_we, grf_we, grf_wsel, grf_dsel,
           alu_op, alu_bsel, ext_op, dm_we, dm_re, halted, state
  );

  modport master (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_sel, ir_we, grf_we, grf_wsel, grf_dsel,
           alu_op, alu_bsel, ext_op, dm_we, dm_re, halted, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: one-hot class plus illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output instr_cls_t cls_o,
  output logic       illegal_o
);

  // Map opcode/funct to exactly one class bit, none for unsupported encodings
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_NOP:  cls_o.nop  = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          default: cls_o      = '0;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: cls_o     = '0;
    endcase
  end

  assign illegal_o = (cls_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional MC_MEM_WAIT_EN: FETCH and MEM stall while mem_ready is low.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.slave  bus
);

  state_e     state_q, state_d;
  instr_cls_t cls_s;
  logic       illegal_s;
  logic       mem_ok_s;
  logic       pc_we_s, ir_we_s, grf_we_s, dm_we_s, dm_re_s, halted_s;
  logic [1:0] pc_sel_s, grf_wsel_s, grf_dsel_s;
  logic [2:0] alu_op_s;
  logic       alu_bsel_s, ext_op_s;

  mc_decode u_decode (
    .opcode_i  (bus.opcode),
    .funct_i   (bus.funct),
    .cls_o     (cls_s),
    .illegal_o (illegal_s)
  );

`ifdef MC_MEM_WAIT_EN
  assign mem_ok_s = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok_s         = 1'b1;
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state enables
  always_comb begin
    state_d    = state_q;
    pc_we_s    = 1'b0;
    pc_sel_s   = PC_SEL_PC4;
    ir_we_s    = 1'b0;
    grf_we_s   = 1'b0;
    grf_wsel_s = WSEL_RT;
    grf_dsel_s = DSEL_ALU;
    dm_we_s    = 1'b0;
    dm_re_s    = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_we_s = mem_ok_s;
        pc_we_s = mem_ok_s;
        state_d = mem_ok_s ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        if (illegal_s) begin
          state_d = ST_HALT;
        end else if (cls_s.jal) begin
          pc_we_s    = 1'b1;
          pc_sel_s   = PC_SEL_J;
          grf_we_s   = 1'b1;
          grf_wsel_s = WSEL_RA;
          grf_dsel_s = DSEL_PC;
          state_d    = ST_FETCH;
        end else if (cls_s.jr) begin
          pc_we_s  = 1'b1;
          pc_sel_s = PC_SEL_RS;
          state_d  = ST_FETCH;
        end else if (cls_s.nop) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_s.beq) begin
          pc_we_s  = bus.zero;
          pc_sel_s = PC_SEL_BR;
          state_d  = ST_FETCH;
        end else if (cls_s.lw || cls_s.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dm_we_s = cls_s.sw;
        dm_re_s = cls_s.lw;
        if (!mem_ok_s) begin
          state_d = ST_MEM;
        end else begin
          state_d = cls_s.lw ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        grf_we_s   = 1'b1;
        grf_wsel_s = (cls_s.addu || cls_s.subu) ? WSEL_RD : WSEL_RT;
        grf_dsel_s = cls_s.lw ? DSEL_DM : DSEL_ALU;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        halted_s = 1'b1;
        state_d  = ST_HALT;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // ALU/EXT selects stay stable from EXEC through MEM and WB
  always_comb begin
    alu_op_s   = ALU_ADD;
    alu_bsel_s = 1'b0;
    ext_op_s   = 1'b0;
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      if (cls_s.subu || cls_s.beq) begin
        alu_op_s = ALU_SUB;
      end else if (cls_s.ori) begin
        alu_op_s   = ALU_OR;
        alu_bsel_s = 1'b1;
      end else if (cls_s.lui) begin
        alu_op_s   = ALU_LUI;
        alu_bsel_s = 1'b1;
      end else if (cls_s.lw || cls_s.sw) begin
        alu_bsel_s = 1'b1;
        ext_op_s   = 1'b1;
      end else begin
        alu_op_s = ALU_ADD;
      end
    end else begin
      alu_op_s = ALU_ADD;
    end
  end

  // Enables are killed combinationally while reset is asserted
  assign bus.pc_we    = pc_we_s  & reset;
  assign bus.ir_we    = ir_we_s  & reset;
  assign bus.grf_we   = grf_we_s & reset;
  assign bus.dm_we    = dm_we_s  & reset;
  assign bus.dm_re    = dm_re_s  & reset;
  assign bus.pc_sel   = pc_sel_s;
  assign bus.grf_wsel = grf_wsel_s;
  assign bus.grf_dsel = grf_dsel_s;
  assign bus.alu_op   = alu_op_s;
  assign bus.alu_bsel = alu_bsel_s;
  assign bus.ext_op   = ext_op_s;
  assign bus.halted   = halted_s;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instruction sequences push expected per-cycle outputs.
module tb_mc_ctrl;

  logic clk;
  logic reset;

  mc_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          tests_run;
  int          tests_failed;
  logic [19:0] act_v;
  logic [19:0] exp_v;
  string       cur_name;

  assign act_v = {bus.pc_we, bus.pc_sel, bus.ir_we, bus.grf_we, bus.grf_wsel, bus.grf_dsel,
                  bus.alu_op, bus.alu_bsel, bus.ext_op, bus.dm_we, bus.dm_re, bus.halted, bus.state};

  // Field order: pc_we pc_sel ir_we grf_we grf_wsel grf_dsel alu_op alu_bsel ext_op dm_we dm_re halted state
  function automatic logic [19:0] mk(input logic [2:0] st, input logic pw, input logic [1:0] ps,
                                     input logic iw, input logic gw, input logic [1:0] ws,
                                     input logic [1:0] ds, input logic [2:0] ao, input logic bs,
                                     input logic eo, input logic dw, input logic dr, input logic h);
    return {pw, ps, iw, gw, ws, ds, ao, bs, eo, dw, dr, h, st};
  endfunction

  function automatic logic [19:0] idle(input logic [2:0] st);
    return mk(st, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] fetch_v();
    return mk(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] halt_v();
    return mk(3'd5, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic tick(input string nm, input logic [19:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  // Monitor: compare one expected vector per cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v    = exp_q.pop_front();
      cur_name = name_q.pop_front();
      tests_run = tests_run + 1;
      if (act_v !== exp_v) begin
        tests_failed = tests_failed + 1;
        $display("FAIL %s: got %05h expected %05h", cur_name, act_v, exp_v);
      end
    end
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    set_ir(6'h0D, 6'h00);
    @(posedge clk);
    #1;
    tick("rst_hold1", idle(3'd0));
    tick("rst_hold2", idle(3'd0));
    reset = 1'b1;

    // ori
    tick("ori_fetch", fetch_v());
    tick("ori_decode", idle(3'd1));
    tick("ori_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("ori_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // lui
    set_ir(6'h0F, 6'h00);
    tick("lui_fetch", fetch_v());
    tick("lui_decode", idle(3'd1));
    tick("lui_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("lui_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // addu
    set_ir(6'h00, 6'h21);
    tick("addu_fetch", fetch_v());
    tick("addu_decode", idle(3'd1));
    tick("addu_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("addu_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // subu
    set_ir(6'h00, 6'h23);
    tick("subu_fetch", fetch_v());
    tick("subu_decode", idle(3'd1));
    tick("subu_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("subu_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // lw
    set_ir(6'h23, 6'h00);
    tick("lw_fetch", fetch_v());
    tick("lw_decode", idle(3'd1));
    tick("lw_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("lw_mem", mk(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    tick("lw_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    // sw
    set_ir(6'h2B, 6'h00);
    tick("sw_fetch", fetch_v());
    tick("sw_decode", idle(3'd1));
    tick("sw_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("sw_mem", mk(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

    // beq taken then not taken
    set_ir(6'h04, 6'h00);
    bus.zero = 1'b1;
    tick("beqt_fetch", fetch_v());
    tick("beqt_decode", idle(3'd1));
    tick("beqt_exec", mk(3'd2, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.zero = 1'b0;
    tick("beqn_fetch", fetch_v());
    tick("beqn_decode", idle(3'd1));
    tick("beqn_exec", mk(3'd2, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // jal, jr, nop
    set_ir(6'h03, 6'h00);
    tick("jal_fetch", fetch_v());
    tick("jal_decode", mk(3'd1, 1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    set_ir(6'h00, 6'h08);
    tick("jr_fetch", fetch_v());
    tick("jr_decode", mk(3'd1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    set_ir(6'h00, 6'h00);
    tick("nop_fetch", fetch_v());
    tick("nop_decode", idle(3'd1));

    // reset in the middle of lw EXEC abandons the instruction
    set_ir(6'h23, 6'h00);
    tick("rmid_fetch", fetch_v());
    tick("rmid_decode", idle(3'd1));
    reset = 1'b0;
    tick("rmid_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    tick("rmid_refetch", fetch_v());
    tick("rmid_redecode", idle(3'd1));
    tick("rmid_reexec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("rmid_mem", mk(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    tick("rmid_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

`ifdef MC_MEM_WAIT_EN
    // lw with a FETCH stall and two MEM wait cycles
    bus.mem_ready = 1'b0;
    tick("wait_fetch_hold", idle(3'd0));
    bus.mem_ready = 1'b1;
    tick("wait_fetch", fetch_v());
    tick("wait_decode", idle(3'd1));
    tick("wait_exec", mk(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick("wait_mem_hold", mk(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    end
    bus.mem_ready = 1'b1;
    tick("wait_mem", mk(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    tick("wait_wb", mk(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
`endif

    // unsupported R-type funct halts
    set_ir(6'h00, 6'h20);
    tick("ilr_fetch", fetch_v());
    tick("ilr_decode", idle(3'd1));
    tick("ilr_halt", halt_v());
    reset = 1'b0;
    tick("ilr_halt_rst", halt_v());
    reset = 1'b1;

    // opcode 0x3F: sticky HALT for 10 cycles, then a single reset edge
    set_ir(6'h3F, 6'h00);
    tick("ill_fetch", fetch_v());
    tick("ill_decode", idle(3'd1));
    for (int i = 0; i < 10; i++) begin
      tick("ill_halt", halt_v());
    end
    reset = 1'b0;
    tick("ill_halt_rst", halt_v());
    reset = 1'b1;
    set_ir(6'h00, 6'h00);
    tick("post_fetch", fetch_v());
    tick("post_decode", idle(3'd1));
    tick("post_fetch2", fetch_v());

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      tests_run    = tests_run + 1;
      tests_failed = tests_failed + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB states. From the current state and the instruction register fields, it drives every write enable and mux select of the PC, IR, GRF, ALU, EXT and DM. It sits beside the datapath inside `mips`, and replaces the single-cycle combinational controller so that instruction and data memory can share latency.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low; reset takes effect when `reset`==0 at a rising edge of `clk`
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU equal flag, used by beq
- `mem_ready`  in  1  memory handshake; ignored unless `MC_MEM_WAIT_EN` is defined
- `pc_we`  out  1  PC write enable
- `pc_sel`  out  2  00 PC+4, 01 branch target, 10 j-immediate, 11 GRF[rs]
- `ir_we`  out  1  IR write enable
- `grf_we`  out  1  register file write enable
- `grf_wsel`  out  2  destination: 00 rt, 01 rd, 10 $31
- `grf_dsel`  out  2  write data: 00 ALU, 01 DM read, 10 PC
- `alu_op`  out  3  000 add, 001 sub, 010 or, 011 lui (B<<16)
- `alu_bsel`  out  1  0 GRF[rt], 1 EXT output
- `ext_op`  out  1  0 zero-extend, 1 sign-extend
- `dm_we`  out  1  data memory write
- `dm_re`  out  1  data memory read
- `halted`  out  1  high in HALT
- `state`  out  3  current state, for debug

## Operation
- Supported instruction classes:
  - addu, subu (op 0, funct 0x21/0x23)
  - nop (op 0, funct 0)
  - jr (op 0, funct 0x08)
  - ori (0x0D), lui (0x0F), lw (0x23), sw (0x2B), beq (0x04), jal (0x03)
  - Anything else is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: `ir_we`=1, `pc_we`=1, `pc_sel`=00. Next state is DECODE.
- DECODE:
  - jal: `pc_we`=1, `pc_sel`=10, `grf_we`=1, `grf_wsel`=10, `grf_dsel`=10. The PC already holds PC+4. Next state is FETCH.
  - jr: `pc_we`=1, `pc_sel`=11. Next state is FETCH.
  - nop: no enables. Next state is FETCH.
  - Illegal: next state is HALT.
  - All others: next state is EXEC.
- EXEC:
  - addu/subu: `alu_op` add/sub, `alu_bsel`=0. Next state is WB.
  - ori/lui: `alu_bsel`=1, `ext_op`=0. Next state is WB.
  - lw/sw: add, `alu_bsel`=1, `ext_op`=1. Next state is MEM.
  - beq: sub, `pc_we`=`zero`, `pc_sel`=01. Next state is FETCH.
- MEM:
  - sw: `dm_we`=1. Next state is FETCH.
  - lw: `dm_re`=1. Next state is WB.
- WB: `grf_we`=1.
  - `grf_wsel` is 01 for R-type and 00 otherwise.
  - `grf_dsel` is 01 for lw and 00 otherwise.
  - Next state is FETCH.
- ALU and EXT selects are held from EXEC through MEM/WB, so datapath inputs stay stable.
- HALT: every enable is 0 and `halted`=1. HALT is sticky until reset.
- Outputs are combinational from `state`, `opcode`, `funct` and `zero`. Only `state` is registered.

## Timing
- Reset:
  - Any edge with `reset`==0 forces state to FETCH.
  - While `reset`==0, all write/read enables are forced to 0 combinationally.
  - The first FETCH write happens on the first edge after release.
- Reset low mid-instruction: the instruction is abandoned and there are no partial writes. PC/IR are not touched by this block.
- Latency without wait states, in cycles:
  - jal/jr/nop: 2
  - beq: 3
  - addu/subu/ori/lui/sw: 4
  - lw: 5
- Writes commit at the rising edge ending the state that asserts them.
- beq not taken: `pc_we`=0 in EXEC, and the PC keeps PC+4.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - FETCH and MEM hold state while `mem_ready`==0.
  - During that hold, `pc_we`, `ir_we` and `grf_we` are 0.
  - `dm_we`/`dm_re` stay asserted throughout MEM; the write takes effect only in the cycle `mem_ready`==1.
  - Each wait cycle adds exactly one cycle of latency.
- `MC_MEM_WAIT_EN` undefined: `mem_ready` is ignored and every state lasts one cycle.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct constants
  - the state enum (3-bit)
  - `pc_sel`, `grf_wsel`, `grf_dsel` and `alu_op` encodings
- Sub-module `mc_decode` is combinational. It maps opcode/funct to one-hot instruction class plus an `illegal` flag, and is instantiated once.

## Test plan
- Reset held low 3 cycles, then released → `state`=0 with all enables 0 during reset. The first edge after release performs `ir_we`/`pc_we`, then `state`=1.
- ori (op 0x0D) → `state` sequence 0,1,2,4,0. WB shows `grf_we`=1, `grf_wsel`=00, `alu_bsel`=1, `ext_op`=0.
- lw (0x23) → sequence 0,1,2,3,4,0. `dm_re`=1 in MEM, `grf_dsel`=01 in WB. With `MC_MEM_WAIT_EN` and `mem_ready` low 2 cycles in MEM → total of 7 cycles.
- beq with `zero`=1 → `pc_we`=1, `pc_sel`=01 in EXEC. beq with `zero`=0 → `pc_we`=0, then FETCH.
- jal → DECODE shows `pc_sel`=10, `grf_we`=1, `grf_wsel`=10, `grf_dsel`=10, and returns to FETCH after 2 cycles.
- opcode 0x3F → HALT after DECODE with `halted`=1 and no enables for 10 cycles. Reset low for 1 edge → FETCH.
